// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel deserializer that hunts for a comma, locks word boundaries and delivers aligned words.
// Build option SP_COMMA_STRIP_EN: boundary words equal to COMMA are not delivered while locked.
module serial_paralelo_align #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             comma_out,
    output logic             active
);
    localparam int FW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [CW-1:0]    comma_cnt_q;
    logic [MW-1:0]    miss_cnt_q;
    logic             hit;
    logic             boundary;

    // The fill qualifier keeps the all-zero reset contents from ever matching.
    always_comb begin
        sr_d     = {sr_q[WIDTH-2:0], data_in};
        fill_d   = (fill_q == FW'(WIDTH)) ? fill_q : fill_q + FW'(1);
        phase_d  = (phase_q == PW'(WIDTH - 1)) ? '0 : phase_q + PW'(1);
        hit      = (sr_q == COMMA) && (fill_q == FW'(WIDTH));
        boundary = (phase_q == '0);
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            fill_q      <= '0;
            phase_q     <= '0;
            comma_cnt_q <= '0;
            miss_cnt_q  <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            comma_out   <= 1'b0;
            active      <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            phase_q   <= phase_d;
            valid_out <= 1'b0;
            comma_out <= 1'b0;
            case (state_q)
                SEARCH: begin
                    // A hit defines phase 0; the next aligned word lands WIDTH cycles later.
                    if (hit) begin
                        phase_q     <= PW'(1);
                        comma_cnt_q <= CW'(1);
                        miss_cnt_q  <= '0;
                        if (LOCK_COUNT == 1) begin
                            state_q <= LOCKED;
                            active  <= 1'b1;
                        end else begin
                            state_q <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        if (hit) begin
                            if (int'(comma_cnt_q) + 1 >= LOCK_COUNT) begin
                                comma_cnt_q <= CW'(LOCK_COUNT);
                                state_q     <= LOCKED;
                                active      <= 1'b1;
                            end else begin
                                comma_cnt_q <= comma_cnt_q + CW'(1);
                            end
                        end else begin
                            comma_cnt_q <= '0;
                            state_q     <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        if (hit) begin
                            miss_cnt_q <= '0;
                        end
`ifdef SP_COMMA_STRIP_EN
                        if (!hit) begin
                            data_out  <= sr_q;
                            valid_out <= 1'b1;
                        end
`else
                        data_out  <= sr_q;
                        valid_out <= 1'b1;
                        comma_out <= hit;
`endif
                    end else if (hit) begin
                        // A comma off the boundary means the lane may have slipped.
                        if (int'(miss_cnt_q) + 1 >= LOSS_COUNT) begin
                            miss_cnt_q  <= '0;
                            comma_cnt_q <= '0;
                            state_q     <= SEARCH;
                            active      <= 1'b0;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + MW'(1);
                        end
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_paralelo_align.sv
// Bench for serial_paralelo_align: WIDTH=8 and WIDTH=10 instances against a bit-position reference model.
module tb_serial_paralelo_align;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       din8 = 1'b0;
    logic       din10 = 1'b0;
    logic [7:0] dout8;
    logic       v8, c8, a8;
    logic [9:0] dout10;
    logic       v10, c10, a10;

    serial_paralelo_align #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_COUNT(4)) dut8 (
        .clk_32f(clk), .reset(reset), .data_in(din8),
        .data_out(dout8), .valid_out(v8), .comma_out(c8), .active(a8)
    );

    serial_paralelo_align #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(4), .LOSS_COUNT(4)) dut10 (
        .clk_32f(clk), .reset(reset), .data_in(din10),
        .data_out(dout10), .valid_out(v10), .comma_out(c10), .active(a10)
    );

    localparam int LOCKN = 4;
    localparam int LOSSN = 4;

    int errors = 0;
    int checks = 0;
    int mw[2] = '{8, 10};
    int mc[2] = '{'hBC, 'h17C};

    // Reference model: state 0 hunting, 1 counting aligned commas, 2 locked.
    // Boundaries are tracked as bit positions congruent to the anchoring comma.
    int m_state[2], m_anchor[2], m_cc[2], m_mc[2], m_word[2], m_n[2];
    int e_data[2], e_valid[2], e_comma[2], e_active[2];

    int got8_d[$];
    int got8_c[$];
    int got10_d[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_anchor[d] = 0; m_cc[d] = 0; m_mc[d] = 0;
            m_word[d] = 0; m_n[d] = 0;
            e_data[d] = 0; e_valid[d] = 0; e_comma[d] = 0; e_active[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic b);
        int  wd, w, n;
        bit  h, bnd;
        wd  = mw[d];
        w   = m_word[d];
        n   = m_n[d];
        h   = (n >= wd) && (w == mc[d]);
        bnd = (m_state[d] != 0) && (((n - m_anchor[d]) % wd) == 0);
        e_valid[d] = 0;
        e_comma[d] = 0;
        if (m_state[d] == 0) begin
            if (h) begin
                m_anchor[d] = n; m_cc[d] = 1; m_mc[d] = 0;
                if (LOCKN == 1) begin m_state[d] = 2; e_active[d] = 1; end
                else m_state[d] = 1;
            end
        end else if (m_state[d] == 1) begin
            if (bnd) begin
                if (h) begin
                    m_cc[d]++;
                    if (m_cc[d] >= LOCKN) begin m_state[d] = 2; e_active[d] = 1; end
                end else begin
                    m_cc[d] = 0; m_state[d] = 0;
                end
            end
        end else begin
            if (bnd) begin
                if (h) m_mc[d] = 0;
`ifdef SP_COMMA_STRIP_EN
                if (!h) begin e_data[d] = w; e_valid[d] = 1; end
`else
                e_data[d] = w; e_valid[d] = 1; e_comma[d] = h ? 1 : 0;
`endif
            end else if (h) begin
                m_mc[d]++;
                if (m_mc[d] >= LOSSN) begin
                    m_state[d] = 0; e_active[d] = 0; m_mc[d] = 0; m_cc[d] = 0;
                end
            end
        end
        m_word[d] = ((w << 1) | int'(b)) & ((1 << wd) - 1);
        m_n[d]    = n + 1;
    endtask

    task automatic check_outputs();
        logic [10:0] exp8;
        logic [12:0] exp10;
        exp8  = {e_active[0][0], e_valid[0][0], e_comma[0][0], e_data[0][7:0]};
        exp10 = {e_active[1][0], e_valid[1][0], e_comma[1][0], e_data[1][9:0]};
        chk("dut8_outputs", 32'({a8, v8, c8, dout8}), 32'(exp8));
        chk("dut10_outputs", 32'({a10, v10, c10, dout10}), 32'(exp10));
        if (v8 === 1'b1) begin
            got8_d.push_back(int'(dout8));
            got8_c.push_back(int'(c8));
            $display("t=%0t dut8 deliver data=0x%02h comma=%0b active=%0b", $time, dout8, c8, a8);
        end
        if (v10 === 1'b1) begin
            got10_d.push_back(int'(dout10));
            $display("t=%0t dut10 deliver data=0x%03h comma=%0b active=%0b", $time, dout10, c10, a10);
        end
    endtask

    // Called just after a rising edge; drives the bit sampled on the next edge.
    task automatic send_bit(input int d, input logic b);
        din8  = (d == 0) ? b : 1'b0;
        din10 = (d == 1) ? b : 1'b0;
        @(posedge clk);
        #1;
        model_step(0, din8);
        model_step(1, din10);
        check_outputs();
    endtask

    task automatic send_word(input int d, input int w);
        for (int i = mw[d] - 1; i >= 0; i--) send_bit(d, w[i]);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        reset = 1'b0;
        got8_d.delete(); got8_c.delete(); got10_d.delete();
    endtask

    initial begin
        // Lock sequence
        model_reset();
        do_reset(3);
        chk("reset_active", 32'(a8), 32'd0);
        chk("reset_data", 32'(dout8), 32'd0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) send_word(0, 'hBC);
        chk("lock_not_yet", 32'(a8), 32'd0);
        send_word(0, 'h55);
        chk("lock_active", 32'(a8), 32'd1);
        send_word(0, 'hA3);
        send_bit(0, 1'($urandom_range(0, 1)));
        chk("lock_nvalid", 32'(got8_d.size()), 32'd2);
        if (got8_d.size() == 2) begin
            chk("lock_word0", 32'(got8_d[0]), 32'h55);
            chk("lock_word1", 32'(got8_d[1]), 32'hA3);
            chk("lock_comma", 32'(got8_c[0] | got8_c[1]), 32'd0);
        end

        // Broken acquisition, then loss of lock
        do_reset(2);
        send_word(0, 'hBC); send_word(0, 'hBC); send_word(0, 'h12);
        for (int i = 0; i < 3; i++) send_word(0, 'hBC);
        chk("broken_not_locked", 32'(a8), 32'd0);
        send_word(0, 'hBC);
        send_word(0, 'h77);
        chk("broken_no_early_valid", 32'(got8_d.size()), 32'd0);
        chk("broken_active", 32'(a8), 32'd1);
        send_word(0, 'h5A);
        chk("broken_nvalid", 32'(got8_d.size()), 32'd1);
        if (got8_d.size() == 1) chk("broken_word0", 32'(got8_d[0]), 32'h77);
        got8_d.delete(); got8_c.delete();
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_word(0, 'hBC);
        chk("loss_still_active", 32'(a8), 32'd1);
        chk("loss_nvalid", 32'(got8_d.size()), 32'd5);
        if (got8_d.size() == 5) chk("loss_last_word", 32'(got8_d[4]), 32'h5E);
        send_bit(0, 1'b0);
        chk("loss_active_low", 32'(a8), 32'd0);
        got8_d.delete(); got8_c.delete();
        for (int i = 0; i < 16; i++) send_bit(0, 1'b0);
        chk("loss_no_valid", 32'(got8_d.size()), 32'd0);
        chk("loss_data_hold", 32'(dout8), 32'h5E);

        // Odd offset on the 10-bit lane
        do_reset(2);
        for (int i = 0; i < 5; i++) send_bit(1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) send_word(1, 'h17C);
        send_word(1, 'h2AA);
        send_bit(1, 1'b0);
        chk("w10_active", 32'(a10), 32'd1);
        chk("w10_nvalid", 32'(got10_d.size()), 32'd1);
        if (got10_d.size() == 1) chk("w10_word", 32'(got10_d[0]), 32'h2AA);

        // Comma delivery
        do_reset(2);
        for (int i = 0; i < 4; i++) send_word(0, 'hBC);
        send_word(0, 'h3C); send_word(0, 'hBC); send_word(0, 'h3C);
        send_bit(0, 1'b0);
`ifdef SP_COMMA_STRIP_EN
        chk("strip_nvalid", 32'(got8_d.size()), 32'd2);
        if (got8_d.size() == 2) begin
            chk("strip_word0", 32'(got8_d[0]), 32'h3C);
            chk("strip_word1", 32'(got8_d[1]), 32'h3C);
            chk("strip_comma", 32'(got8_c[0] | got8_c[1]), 32'd0);
        end
`else
        chk("comma_nvalid", 32'(got8_d.size()), 32'd3);
        if (got8_d.size() == 3) begin
            chk("comma_words", 32'({got8_d[0][7:0], got8_d[1][7:0], got8_d[2][7:0]}), 32'h3CBC3C);
            chk("comma_flags", 32'({got8_c[0][0], got8_c[1][0], got8_c[2][0]}), 32'b010);
        end
`endif

        // Asynchronous reset while locked
        #2;
        reset = 1'b1;
        #1;
        chk("areset_outputs", 32'({a8, v8, c8, dout8}), 32'd0);
        #1;
        do_reset(2);
        for (int i = 0; i < 3; i++) send_word(0, 'hBC);
        chk("relock_3_commas", 32'(a8), 32'd0);
        send_word(0, 'hBC);
        chk("relock_4_pending", 32'(a8), 32'd0);
        send_bit(0, 1'b0);
        chk("relock_active", 32'(a8), 32'd1);

        // Random payload after a random offset, checked cycle by cycle against the model
        do_reset(2);
        for (int i = 0, n = $urandom_range(0, 7); i < n; i++) send_bit(0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) send_word(0, 'hBC);
        for (int i = 0; i < 24; i++) send_word(0, int'($urandom_range(0, 255)));
        send_bit(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
